joybus_cmd_rx: RTL and testbench

Parametrised console-side command receiver for the fake N64 controller: a single-clock successor to the derived-clock receiver.
- Oversamples the raw Joybus line on `clk` and decodes bits by low-pulse width.
- Frames command byte, 16-bit address field and write payload by command length.
- Computes the data CRC, optionally checks the address CRC, and hands a completed frame to the TX side with a one-cycle strobe.

---
 rtl/joybus_cmd_rx.sv | 245 ++++++++++++++++++++++++
 tb/tb_joybus_cmd_rx.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/joybus_cmd_rx.sv
// Joybus console-command receiver, single clock domain.
// Oversamples the raw line, decodes bits by low-pulse width, frames
// cmd / address / payload by command length and strobes a finished frame.
// Optional build macro: JOYBUS_RX_ADDR_CRC_EN (CRC-5 check of the address field).
//
// state | meaning
// IDLE  | waiting for the first falling edge of a frame
// LOW   | line low inside a data bit, width is being measured
// HIGH  | line high between data bits
// STOP  | all data bits received, waiting for the stop pulse
module joybus_cmd_rx #(
  parameter int         CLKS_PER_US   = 16,
  parameter int         PAYLOAD_BYTES = 32,
  parameter int         TIMEOUT_US    = 8,
  parameter logic [7:0] CMD_READ      = 8'h02,
  parameter logic [7:0] CMD_WRITE     = 8'h03
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rx_enable,
  input  logic                             data_rx,
  output logic                             frame_valid,
  output logic                             frame_err,
  output logic [7:0]                       cmd,
  output logic [15:0]                      address,
  output logic                             cmd_unknown,
  output logic                             addr_err,
  output logic [7:0]                       data_crc,
  input  logic [$clog2(PAYLOAD_BYTES)-1:0] rd_addr,
  output logic [7:0]                       rd_data
);

  localparam int THR    = 2 * CLKS_PER_US;
  localparam int TO_CYC = TIMEOUT_US * CLKS_PER_US;
  localparam int BCW    = $clog2(25 + 8 * PAYLOAD_BYTES);
  localparam int AW     = $clog2(PAYLOAD_BYTES);
  localparam int LCW    = $clog2(THR + 1);
  localparam int TW     = $clog2(TO_CYC);

  localparam logic [LCW-1:0] THR_V        = LCW'(THR);
  localparam logic [TW-1:0]  TO_LOAD      = TW'(TO_CYC - 1);
  localparam logic [BCW-1:0] B_CMD_LAST   = BCW'(7);
  localparam logic [BCW-1:0] B_ADDR_FIRST = BCW'(8);
  localparam logic [BCW-1:0] B_CRC5_LAST  = BCW'(18);
  localparam logic [BCW-1:0] B_ADDR_LAST  = BCW'(23);
  localparam logic [BCW-1:0] B_PAY_FIRST  = BCW'(24);
  localparam logic [BCW-1:0] B_PAY_LAST   = BCW'(23 + 8 * PAYLOAD_BYTES);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, STOP} state_t;

  state_t           state;
  logic             rx_s1, rx_s2, rx_d;
  logic             fall, rise;
  logic [LCW-1:0]   low_cnt;
  logic [TW-1:0]    tmr;
  logic [BCW-1:0]   bit_cnt;
  logic [7:0]       cmd_sh;
  logic [15:0]      addr_sh;
  logic [6:0]       byte_sh;
  logic [7:0]       crc8;
  logic [AW-1:0]    wr_idx;
  logic             bit_val;
  logic [7:0]       cmd_next;
  logic [7:0]       crc8_next;
  logic             last_bit;
  logic             ram_we;
  logic [7:0]       ram_wdata;
  logic             cmd_known;
  logic             addr_err_next;
  logic [7:0]       mem [PAYLOAD_BYTES];
`ifdef JOYBUS_RX_ADDR_CRC_EN
  logic [4:0]       crc5;
  logic [4:0]       crc5_next;
`endif

  assign fall = rx_d & ~rx_s2;
  assign rise = ~rx_d & rx_s2;

  // Two-flop synchroniser plus one delay flop for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= data_rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // Saturating low-pulse width counter; holds the width at the rising edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      low_cnt <= '0;
    end else if (fall) begin
      low_cnt <= LCW'(1);
    end else if (!rx_s2 && low_cnt != THR_V) begin
      low_cnt <= low_cnt + LCW'(1);
    end
  end

  // Bit decode, frame-length decision and CRC next values.
  always_comb begin
    bit_val   = (low_cnt < THR_V);
    cmd_next  = {cmd_sh[6:0], bit_val};
    crc8_next = {crc8[6:0], 1'b0} ^ ((crc8[7] ^ bit_val) ? 8'h85 : 8'h00);
    last_bit  = 1'b0;
    if (bit_cnt == B_CMD_LAST)
      last_bit = (cmd_next != CMD_READ) && (cmd_next != CMD_WRITE);
    else if (bit_cnt == B_ADDR_LAST)
      last_bit = (cmd_sh == CMD_READ);
    else if (bit_cnt == B_PAY_LAST)
      last_bit = 1'b1;
    ram_we    = rx_enable && (state == LOW) && rise &&
                (bit_cnt >= B_PAY_FIRST) && (bit_cnt[2:0] == 3'b111);
    ram_wdata = {byte_sh, bit_val};
    cmd_known = (cmd_sh == 8'h00) || (cmd_sh == 8'h01) || (cmd_sh == 8'hFF) ||
                (cmd_sh == CMD_READ) || (cmd_sh == CMD_WRITE);
`ifdef JOYBUS_RX_ADDR_CRC_EN
    crc5_next     = {crc5[3:0], 1'b0} ^ ((crc5[4] ^ bit_val) ? 5'h15 : 5'h00);
    addr_err_next = ((cmd_sh == CMD_READ) || (cmd_sh == CMD_WRITE)) &&
                    (crc5 != addr_sh[4:0]);
`else
    addr_err_next = 1'b0;
`endif
  end

  // Receive FSM: framing, shadow registers, timeout and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      tmr         <= '0;
      bit_cnt     <= '0;
      cmd_sh      <= '0;
      addr_sh     <= '0;
      byte_sh     <= '0;
      crc8        <= '0;
      wr_idx      <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      cmd         <= 8'hFE;
      address     <= '0;
      cmd_unknown <= 1'b0;
      addr_err    <= 1'b0;
      data_crc    <= '0;
`ifdef JOYBUS_RX_ADDR_CRC_EN
      crc5        <= '0;
`endif
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (!rx_enable) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (fall) begin
              state   <= LOW;
              tmr     <= TO_LOAD;
              bit_cnt <= '0;
              cmd_sh  <= '0;
              addr_sh <= '0;
              byte_sh <= '0;
              crc8    <= '0;
              wr_idx  <= '0;
`ifdef JOYBUS_RX_ADDR_CRC_EN
              crc5    <= '0;
`endif
            end
          end
          LOW: begin
            if (rise) begin
              tmr     <= TO_LOAD;
              bit_cnt <= bit_cnt + BCW'(1);
              state   <= last_bit ? STOP : HIGH;
              if (bit_cnt < B_ADDR_FIRST) begin
                cmd_sh <= cmd_next;
              end else if (bit_cnt < B_PAY_FIRST) begin
                addr_sh <= {addr_sh[14:0], bit_val};
`ifdef JOYBUS_RX_ADDR_CRC_EN
                if (bit_cnt <= B_CRC5_LAST) crc5 <= crc5_next;
`endif
              end else begin
                byte_sh <= {byte_sh[5:0], bit_val};
                crc8    <= crc8_next;
                if (ram_we) wr_idx <= wr_idx + AW'(1);
              end
            end else if (tmr == '0) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
          HIGH: begin
            if (fall) begin
              tmr   <= TO_LOAD;
              state <= LOW;
            end else if (tmr == '0) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
          STOP: begin
            if (rise) begin
              state <= IDLE;
              if (bit_val) begin
                frame_valid <= 1'b1;
                cmd         <= cmd_sh;
                address     <= addr_sh;
                cmd_unknown <= !cmd_known;
                addr_err    <= addr_err_next;
                data_crc    <= crc8;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (fall) begin
              tmr <= TO_LOAD;
            end else if (tmr == '0) begin
              frame_err <= 1'b1;
              state     <= IDLE;
            end else begin
              tmr <= tmr - TW'(1);
            end
          end
        endcase
      end
    end
  end

  // Payload buffer write port; contents deliberately not reset.
  always_ff @(posedge clk) begin
    if (ram_we) mem[wr_idx] <= ram_wdata;
  end

  // Registered payload read port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) rd_data <= '0;
    else       rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_joybus_cmd_rx.sv
// Self-checking bench for joybus_cmd_rx with directed Joybus frames.
// Honours JOYBUS_RX_ADDR_CRC_EN the same way the design does.
module tb_joybus_cmd_rx;

  localparam int US = 16;
  localparam logic [7:0] RD = 8'h02;
  localparam logic [7:0] WR = 8'h03;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_enable;
  logic        data_rx;
  logic        frame_valid, frame_err;
  logic [7:0]  cmd;
  logic [15:0] address;
  logic        cmd_unknown, addr_err;
  logic [7:0]  data_crc;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_data;

  joybus_cmd_rx dut (
    .clk(clk), .reset(reset), .rx_enable(rx_enable), .data_rx(data_rx),
    .frame_valid(frame_valid), .frame_err(frame_err), .cmd(cmd),
    .address(address), .cmd_unknown(cmd_unknown), .addr_err(addr_err),
    .data_crc(data_crc), .rd_addr(rd_addr), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_err = 0;
  int valid_cyc = -1;

  // model state: what the persistent outputs must currently be
  logic [7:0]  m_cmd = 8'hFE;
  logic [15:0] m_addr = 16'h0000;
  logic        m_unk = 1'b0;
  logic        m_aerr = 1'b0;
  logic [7:0]  m_crc = 8'h00;
  // frame the model expects to complete next
  logic        p_valid = 1'b0;
  logic [7:0]  p_cmd;
  logic [15:0] p_addr;
  logic        p_unk, p_aerr;
  logic [7:0]  p_crc;
  logic [7:0]  pay [32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] crc8_bytes(input int n);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < n; i++) begin
      c = c ^ pay[i];
      for (int k = 0; k < 8; k++) c = c[7] ? ((c << 1) ^ 8'h85) : (c << 1);
    end
    return c;
  endfunction

  // remainder of (v * x^5) modulo x^5+x^4+x^2+1
  function automatic logic [4:0] crc5_of(input logic [10:0] v);
    logic [15:0] r = {v, 5'b0};
    for (int i = 15; i >= 5; i--)
      if (r[i]) r = r ^ (16'h0035 << (i - 5));
    return r[4:0];
  endfunction

  task automatic expect_frame(input logic [7:0] c, input logic [15:0] a);
    logic has_addr;
    has_addr = (c == RD) || (c == WR);
    p_cmd  = c;
    p_addr = has_addr ? a : 16'h0000;
    p_crc  = (c == WR) ? crc8_bytes(32) : 8'h00;
    p_unk  = !(c == 8'h00 || c == 8'h01 || c == 8'hFF || has_addr);
`ifdef JOYBUS_RX_ADDR_CRC_EN
    p_aerr = has_addr && (crc5_of(a[15:5]) != a[4:0]);
`else
    p_aerr = 1'b0;
`endif
    p_valid = 1'b1;
  endtask

  // compare process: strobes against the model, persistent outputs every cycle
  always @(negedge clk) begin
    if (!reset) begin
      if (frame_valid && frame_err) begin
        errors++;
        $display("FAIL strobes: valid=%b err=%b together", frame_valid, frame_err);
      end
      if (frame_err) n_err++;
      if (frame_valid) begin
        n_valid++;
        valid_cyc = cyc;
        checks++;
        if (!p_valid) begin
          errors++;
          $display("FAIL unexpected_valid: got 1 expected 0 at cycle %0d", cyc);
        end else begin
          m_cmd = p_cmd; m_addr = p_addr; m_unk = p_unk;
          m_aerr = p_aerr; m_crc = p_crc; p_valid = 1'b0;
        end
      end
      checks++;
      if (cmd !== m_cmd || address !== m_addr || cmd_unknown !== m_unk ||
          addr_err !== m_aerr || data_crc !== m_crc) begin
        errors++;
        $display("FAIL outputs@%0d: got cmd=%h addr=%h unk=%b aerr=%b crc=%h expected cmd=%h addr=%h unk=%b aerr=%b crc=%h",
                 cyc, cmd, address, cmd_unknown, addr_err, data_crc,
                 m_cmd, m_addr, m_unk, m_aerr, m_crc);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic lvl(input logic v, input int n);
    data_rx = v;
    tick(n);
  endtask

  task automatic send_bit_w(input logic b, input int lo1, input int lo0);
    if (b) begin lvl(1'b0, lo1); lvl(1'b1, 4*US - lo1); end
    else   begin lvl(1'b0, lo0); lvl(1'b1, 4*US - lo0); end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit_w(v[i], US, 3*US);
  endtask

  // stop pulse then idle; returns the cycle on which the line was released
  task automatic send_stop(input int lo, output int rise_at);
    lvl(1'b0, lo);
    data_rx = 1'b1;
    rise_at = cyc;
    tick(6*US);
  endtask

  task automatic chk_counts(input string name, input int v0, input int e0,
                            input int dv, input int de);
    chk({name, "_valid_count"}, n_valid - v0, dv);
    chk({name, "_err_count"}, n_err - e0, de);
  endtask

  initial begin
    int v0, e0, r_at;
    reset = 1'b1; rx_enable = 1'b1; data_rx = 1'b1; rd_addr = '0;
    tick(3);
    chk("reset_cmd", cmd, 8'hFE);
    chk("reset_address", address, 0);
    chk("reset_flags", {frame_valid, frame_err, cmd_unknown, addr_err}, 0);
    chk("reset_data_crc", data_crc, 0);
    chk("reset_rd_data", rd_data, 0);
    reset = 1'b0;
    tick(2*US);

    // 1: 0x00 + stop
    v0 = n_valid; e0 = n_err;
    expect_frame(8'h00, 16'h0000);
    send_byte(8'h00);
    send_stop(US, r_at);
    chk_counts("s1", v0, e0, 1, 0);
    chk("s1_valid_latency", valid_cyc - r_at, 3);
    chk("s1_cmd", cmd, 8'h00);
    chk("s1_unknown", cmd_unknown, 0);
    chk("s1_crc", data_crc, 8'h00);

    // 2: write 0x0035 with payload 31x00, 01
    for (int i = 0; i < 32; i++) pay[i] = 8'h00;
    pay[31] = 8'h01;
    v0 = n_valid; e0 = n_err;
    expect_frame(WR, 16'h0035);
    send_byte(WR); send_byte(8'h00); send_byte(8'h35);
    for (int i = 0; i < 32; i++) send_byte(pay[i]);
    send_stop(US, r_at);
    chk_counts("s2", v0, e0, 1, 0);
    chk("s2_address", address, 16'h0035);
    chk("s2_crc", data_crc, 8'h85);
    chk("s2_addr_err", addr_err, 0);
    chk("model_crc5_0035", crc5_of(11'h001), 5'h15);
    for (int i = 0; i < 32; i++) begin
      rd_addr = 5'(i);
      tick(1);
      chk($sformatf("s2_rd_data[%0d]", i), rd_data, pay[i]);
    end

    // 4: read aborted by a 9us low after bit 12
    v0 = n_valid; e0 = n_err;
    send_byte(RD);
    for (int i = 0; i < 4; i++) send_bit_w(1'b0, US, 3*US);
    lvl(1'b0, 9*US);
    lvl(1'b1, 10*US);
    chk_counts("s4", v0, e0, 0, 1);
    chk("s4_cmd_kept", cmd, 8'h03);
    chk("s4_address_kept", address, 16'h0035);

    // 3: read 0x0034, address CRC-5 deliberately wrong
    v0 = n_valid; e0 = n_err;
    expect_frame(RD, 16'h0034);
    send_byte(RD); send_byte(8'h00); send_byte(8'h34);
    send_stop(US, r_at);
    chk_counts("s3", v0, e0, 1, 0);
`ifdef JOYBUS_RX_ADDR_CRC_EN
    chk("s3_addr_err", addr_err, 1);
`else
    chk("s3_addr_err", addr_err, 0);
`endif
    chk("s3_address", address, 16'h0034);

    // 5: rx_enable dropped mid-payload, then 0xFF
    v0 = n_valid; e0 = n_err;
    send_byte(WR); send_byte(8'h00); send_byte(8'h35);
    for (int i = 0; i < 3; i++) send_byte(8'hC3);
    lvl(1'b0, 10);
    rx_enable = 1'b0;
    lvl(1'b0, 20);
    lvl(1'b1, US);
    send_byte(8'hAA);
    lvl(1'b0, 3*US);
    lvl(1'b1, 2*US);
    rx_enable = 1'b1;
    tick(2*US);
    chk_counts("s5_disabled", v0, e0, 0, 0);
    expect_frame(8'hFF, 16'h0000);
    send_byte(8'hFF);
    send_stop(US, r_at);
    chk_counts("s5", v0, e0, 1, 0);
    chk("s5_cmd", cmd, 8'hFF);
    chk("s5_address", address, 0);

    // 6: unknown 0x5A, then 0x01 with a long stop pulse
    v0 = n_valid; e0 = n_err;
    expect_frame(8'h5A, 16'h0000);
    send_byte(8'h5A);
    send_stop(US, r_at);
    chk_counts("s6a", v0, e0, 1, 0);
    chk("s6a_unknown", cmd_unknown, 1);
    v0 = n_valid; e0 = n_err;
    send_byte(8'h01);
    send_stop(3*US, r_at);
    chk_counts("s6b", v0, e0, 0, 1);
    chk("s6b_cmd_kept", cmd, 8'h5A);

    // 7: pulse widths just either side of the 2us threshold
    v0 = n_valid; e0 = n_err;
    expect_frame(8'hA5, 16'h0000);
    for (int i = 7; i >= 0; i--) send_bit_w(((8'hA5 >> i) & 8'h01) != 0, 2*US - 2, 2*US + 2);
    send_stop(2*US - 2, r_at);
    chk_counts("s7", v0, e0, 1, 0);
    chk("s7_cmd", cmd, 8'hA5);

    chk("pending_drained", p_valid, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
